// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset PC, NOP encoding and the
// F/D pipeline-latch record used by the fetch stage.
package cpu_pkg;

    localparam int ADDR_W = 12;
    localparam int INSN_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 12'h000;
    localparam logic [INSN_W-1:0] NOP_INSN         = 32'h0000_0000;

    typedef struct packed {
        logic [INSN_W-1:0] insn;
        logic [ADDR_W-1:0] pc_plus1;
        logic              valid;
    } fd_entry_t;

    // An empty latch holds a NOP so downstream decode sees a harmless encoding.
    localparam fd_entry_t FD_RESET = '{insn: NOP_INSN, pc_plus1: '0, valid: 1'b0};

endpackage

// File: rtl/RCA_12bit.sv
// 12-bit ripple-carry adder built from a chain of full-adder cells.
module RCA_12bit
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0] i_a,
    input  logic [ADDR_W-1:0] i_b,
    input  logic              i_cin,
    output logic [ADDR_W-1:0] o_sum,
    output logic              o_cout
);

    logic [ADDR_W:0] w_carry;

    assign w_carry[0] = i_cin;

    for (genvar i = 0; i < ADDR_W; i++) begin : g_fa
        assign o_sum[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
        assign w_carry[i + 1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = w_carry[ADDR_W];

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: program counter, next-PC selection (branch, jump,
// stall, sequential) and the F/D pipeline latch feeding decode.
module fetch_pc_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_base,
    input  logic [ADDR_W-1:0] branch_offset,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INSN_W-1:0] imem_data,
    output logic [INSN_W-1:0] fd_insn,
    output logic [ADDR_W-1:0] fd_pc_plus1,
    output logic              fd_valid
);

    logic [ADDR_W-1:0] r_pc;
    fd_entry_t         r_fd;

    logic [ADDR_W-1:0] w_pc_plus1;
    logic [ADDR_W-1:0] w_br_target;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_redirect;
    // Both carry-outs are dropped so PC arithmetic wraps modulo 4096.
    logic [1:0]        w_unused_carry;

    RCA_12bit u_pc_inc (
        .i_a    (r_pc),
        .i_b    (12'h001),
        .i_cin  (1'b0),
        .o_sum  (w_pc_plus1),
        .o_cout (w_unused_carry[0])
    );

    RCA_12bit u_br_tgt (
        .i_a    (branch_base),
        .i_b    (branch_offset),
        .i_cin  (1'b0),
        .o_sum  (w_br_target),
        .o_cout (w_unused_carry[1])
    );

    assign w_redirect = branch_valid | jump_valid;

    // The branch is older than the jump in decode, so it wins; any redirect beats stall.
    always_comb begin
        // NOTE: default assignment first so no path through the block can infer a latch.
        w_next_pc = w_pc_plus1;
        if (branch_valid)
            w_next_pc = w_br_target;
        else if (jump_valid)
            w_next_pc = jump_target;
        else if (stall)
            w_next_pc = r_pc;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= RESET_PC;
            r_fd <= FD_RESET;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_pc <= w_next_pc;
            if (w_redirect)
                r_fd.valid <= 1'b0;
            else if (!stall)
                r_fd <= '{insn: imem_data, pc_plus1: w_pc_plus1, valid: 1'b1};
        end
    end

    assign imem_addr   = r_pc;
    assign fd_insn     = r_fd.insn;
    assign fd_pc_plus1 = r_fd.pc_plus1;
    assign fd_valid    = r_fd.valid;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: table of per-cycle vectors with a
// scoreboard queue, plus a hand-written asynchronous mid-cycle reset sequence.
module tb_fetch_pc_unit;
    import cpu_pkg::*;

    logic              clock;
    logic              reset_n;
    logic              stall;
    logic              branch_valid;
    logic [ADDR_W-1:0] branch_base;
    logic [ADDR_W-1:0] branch_offset;
    logic              jump_valid;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] imem_addr;
    logic [INSN_W-1:0] imem_data;
    logic [INSN_W-1:0] fd_insn;
    logic [ADDR_W-1:0] fd_pc_plus1;
    logic              fd_valid;

    int checks   = 0;
    int failures = 0;

    fetch_pc_unit #(.RESET_PC(12'h000)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .stall         (stall),
        .branch_valid  (branch_valid),
        .branch_base   (branch_base),
        .branch_offset (branch_offset),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .fd_insn       (fd_insn),
        .fd_pc_plus1   (fd_pc_plus1),
        .fd_valid      (fd_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory contents: a unique, address-derived word per location.
    function automatic logic [31:0] insn_at(input logic [11:0] a);
        return {a, ~a, 8'h5A};
    endfunction

    always_comb imem_data = insn_at(imem_addr);

    typedef struct packed {
        logic        st;
        logic        bv;
        logic [11:0] base;
        logic [11:0] off;
        logic        jv;
        logic [11:0] tgt;
        logic [11:0] e_addr;
        logic        e_valid;
        logic [11:0] e_pc1;
        logic [11:0] e_src;   // address whose instruction fd_insn must hold
    } vec_t;

    typedef struct packed {
        logic [11:0] addr;
        logic        valid;
        logic [11:0] pc1;
        logic [31:0] insn;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;

        // st bv base    off     jv tgt     addr   v  pc1    src
        vecs.push_back('{1'b0,1'b0,12'h000,12'h000,1'b0,12'h000, 12'h001,1'b1,12'h001,12'h000});
        vecs.push_back('{1'b0,1'b0,12'h000,12'h000,1'b0,12'h000, 12'h002,1'b1,12'h002,12'h001});
        vecs.push_back('{1'b0,1'b0,12'h000,12'h000,1'b0,12'h000, 12'h003,1'b1,12'h003,12'h002});
        vecs.push_back('{1'b0,1'b0,12'h000,12'h000,1'b0,12'h000, 12'h004,1'b1,12'h004,12'h003});
        vecs.push_back('{1'b0,1'b0,12'h000,12'h000,1'b0,12'h000, 12'h005,1'b1,12'h005,12'h004});
        vecs.push_back('{1'b1,1'b0,12'h000,12'h000,1'b0,12'h000, 12'h005,1'b1,12'h005,12'h004});
        vecs.push_back('{1'b1,1'b0,12'h000,12'h000,1'b0,12'h000, 12'h005,1'b1,12'h005,12'h004});
        vecs.push_back('{1'b0,1'b0,12'h000,12'h000,1'b0,12'h000, 12'h006,1'b1,12'h006,12'h005});
        vecs.push_back('{1'b0,1'b1,12'h010,12'hFFE,1'b0,12'h000, 12'h00E,1'b0,12'h006,12'h005});
        vecs.push_back('{1'b0,1'b0,12'h000,12'h000,1'b0,12'h000, 12'h00F,1'b1,12'h00F,12'h00E});
        vecs.push_back('{1'b0,1'b0,12'h000,12'h000,1'b0,12'h000, 12'h010,1'b1,12'h010,12'h00F});
        vecs.push_back('{1'b1,1'b1,12'h020,12'h004,1'b1,12'h100, 12'h024,1'b0,12'h010,12'h00F});
        vecs.push_back('{1'b0,1'b0,12'h000,12'h000,1'b0,12'h000, 12'h025,1'b1,12'h025,12'h024});
        vecs.push_back('{1'b0,1'b0,12'h000,12'h000,1'b1,12'hFFE, 12'hFFE,1'b0,12'h025,12'h024});
        vecs.push_back('{1'b0,1'b0,12'h000,12'h000,1'b0,12'h000, 12'hFFF,1'b1,12'hFFF,12'hFFE});
        vecs.push_back('{1'b0,1'b0,12'h000,12'h000,1'b0,12'h000, 12'h000,1'b1,12'h000,12'hFFF});
        vecs.push_back('{1'b1,1'b0,12'h000,12'h000,1'b1,12'h0A0, 12'h0A0,1'b0,12'h000,12'hFFF});
        vecs.push_back('{1'b0,1'b1,12'hFF0,12'h020,1'b0,12'h000, 12'h010,1'b0,12'h000,12'hFFF});
        vecs.push_back('{1'b0,1'b0,12'h000,12'h000,1'b0,12'h000, 12'h011,1'b1,12'h011,12'h010});
        vecs.push_back('{1'b1,1'b0,12'h000,12'h000,1'b0,12'h000, 12'h011,1'b1,12'h011,12'h010});
        vecs.push_back('{1'b0,1'b1,12'h040,12'h001,1'b0,12'h000, 12'h041,1'b0,12'h011,12'h010});
        vecs.push_back('{1'b0,1'b1,12'h040,12'h001,1'b0,12'h000, 12'h041,1'b0,12'h011,12'h010});
        vecs.push_back('{1'b0,1'b0,12'h000,12'h000,1'b0,12'h000, 12'h042,1'b1,12'h042,12'h041});

        reset_n       = 1'b0;
        stall         = 1'b0;
        branch_valid  = 1'b0;
        branch_base   = '0;
        branch_offset = '0;
        jump_valid    = 1'b0;
        jump_target   = '0;

        #3;
        check("reset_addr",  32'(imem_addr),   32'h000);
        check("reset_valid", 32'(fd_valid),    32'h0);
        check("reset_insn",  fd_insn,          32'h0);
        check("reset_pc1",   32'(fd_pc_plus1), 32'h000);

        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("cycle0_addr",  32'(imem_addr), 32'h000);
        check("cycle0_valid", 32'(fd_valid),  32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            stall         = vecs[i].st;
            branch_valid  = vecs[i].bv;
            branch_base   = vecs[i].base;
            branch_offset = vecs[i].off;
            jump_valid    = vecs[i].jv;
            jump_target   = vecs[i].tgt;
            sb.push_back('{vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_pc1, insn_at(vecs[i].e_src)});
            @(posedge clock);
            #1;
            if (sb.size() == 0) begin
                check($sformatf("v%0d_scoreboard_empty", i), 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check($sformatf("v%0d_addr", i),  32'(imem_addr),   32'(e.addr));
                check($sformatf("v%0d_valid", i), 32'(fd_valid),    32'(e.valid));
                check($sformatf("v%0d_pc1", i),   32'(fd_pc_plus1), 32'(e.pc1));
                check($sformatf("v%0d_insn", i),  fd_insn,          e.insn);
            end
            @(negedge clock);
        end

        stall        = 1'b0;
        branch_valid = 1'b0;
        jump_valid   = 1'b0;

        // Asynchronous reset asserted mid-cycle during normal fetch.
        @(posedge clock);
        #1;
        check("pre_reset_addr", 32'(imem_addr), 32'h043);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_reset_addr",  32'(imem_addr),   32'h000);
        check("async_reset_valid", 32'(fd_valid),    32'h0);
        check("async_reset_insn",  fd_insn,          32'h0);
        check("async_reset_pc1",   32'(fd_pc_plus1), 32'h000);
        @(posedge clock);
        #1;
        check("reset_held_addr",  32'(imem_addr), 32'h000);
        check("reset_held_valid", 32'(fd_valid),  32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("resume_addr",  32'(imem_addr),   32'h001);
        check("resume_valid", 32'(fd_valid),    32'h1);
        check("resume_pc1",   32'(fd_pc_plus1), 32'h001);
        check("resume_insn",  fd_insn,          insn_at(12'h000));
        @(posedge clock);
        #1;
        check("resume2_addr", 32'(imem_addr),   32'h002);
        check("resume2_pc1",  32'(fd_pc_plus1), 32'h002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
